dense_out_layer: RTL and testbench
==================================

DENSE_OUT_LAYER -- requirements
Module: dense_out_layer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 5, number of logits produced per frame (softmax class count).
REQ-002 SHALL have parameter IDX_W, default 3, width of the logit index; 2^IDX_W >= NUM_OUT.
REQ-003 SHALL have parameter NUM_IN, default 4, number of input features per frame.
REQ-004 SHALL have parameter IN_IDX_W, default 2, width of the feature index; 2^IN_IDX_W >= NUM_IN.
REQ-005 SHALL have ports: clk input 1, sole clock, rising edge; reset is synchronous and active-high (rst input 1).
REQ-006 SHALL have ports: feat_in input 32, signed Q16.16 feature; feat_idx input IN_IDX_W; feat_valid input 1.
REQ-007 SHALL have ports: w_we input 1; w_addr input IN_IDX_W+IDX_W, {out_idx,in_idx}; w_data input 32, signed Q16.16 weight.
REQ-008 SHALL have ports: sf_input output 32, logit; sf_input_idx output IDX_W; start output 1, logit valid; in_ready input 1, softmax accepts.
REQ-009 SHALL have ports: busy output 1; frame_done output 1, one-cycle pulse after last logit transfers.

Function
REQ-010 SHALL run FSM IDLE -> LOAD -> MAC -> STREAM -> IDLE.
REQ-011 IDLE/LOAD: feat_valid stores feat_in at feat_idx; entering LOAD on first feat_valid; feat_idx >= NUM_IN ignored.
REQ-012 LOAD -> MAC when all NUM_IN feature slots have been written since frame start (per-slot flag; rewriting a slot overwrites, does not count twice).
REQ-013 MAC: one multiply-accumulate per cycle, j outer 0..NUM_OUT-1, i inner 0..NUM_IN-1; exactly NUM_OUT*NUM_IN cycles.
REQ-014 Product = 64-bit signed feat*weight; term = product[47:16]; accumulator 32-bit two's complement, wraps on overflow.
REQ-015 Each logit j written to result buffer at end of its inner loop; MAC -> STREAM after j = NUM_OUT-1.
REQ-016 STREAM: start=1, sf_input=logit[k], sf_input_idx=k, k from 0; transfer on cycle with start && in_ready; k increments next cycle.
REQ-017 sf_input/sf_input_idx SHALL hold stable while start=1 and in_ready=0.
REQ-018 After transfer of k = NUM_OUT-1: start=0, frame_done=1 for one cycle, FSM -> IDLE, slot flags cleared.
REQ-019 feat_valid outside IDLE/LOAD SHALL be ignored; w_we SHALL be accepted in all states, but write during MAC takes effect only for products not yet computed.
REQ-020 busy=1 in LOAD, MAC, STREAM; 0 in IDLE.
REQ-021 Weight write and read of the same address in one cycle SHALL return the old weight to the MAC.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, start=0, frame_done=0, busy=0, sf_input=0, sf_input_idx=0, k=0, accumulator=0, slot flags cleared.
REQ-023 Reset mid-frame SHALL abandon the frame with no further start assertion; weight memory SHALL NOT be cleared by reset.

Configuration
REQ-024 Macro DENSE_OUT_LAYER_BIAS_EN defined: per-logit bias registers (32-bit Q16.16) written via w_we with w_addr in_idx field = all-ones (requires NUM_IN < 2^IN_IDX_W); accumulator initialised to bias[j] at start of each j.
REQ-025 Macro undefined: no bias storage, accumulator initialised to 0; all-ones in_idx writes ignored.

Verification
REQ-026 All weights 0x00010000, features 1.0,2.0,3.0,4.0, in_ready=1 -> logits 0..4 each 0x000A0000, indices 0..4 in order, frame_done 1 cycle after last.
REQ-027 Same frame, in_ready toggled 1/0 every cycle -> identical sequence, outputs stable while stalled, 5 transfers total.
REQ-028 Weight w[2][*] = 0xFFFF0000 (-1.0), features all 1.0 -> logit 2 = 0xFFFC0000; others 0x00040000.
REQ-029 Features 0x7FFF0000 with weight 2.0 -> accumulator wraps, logit = 0xFFFC0000 (two's complement).
REQ-030 rst asserted in STREAM after 2 transfers -> start=0 next cycle, busy=0; next frame with unchanged weights reproduces REQ-026 values.
REQ-031 With DENSE_OUT_LAYER_BIAS_EN, bias[0]=0x00008000, REQ-026 stimulus -> logit 0 = 0x000A8000.

Source files
------------

// File: rtl/dense_out_layer.sv
// rtl/dense_out_layer.sv - dense output layer: feature load, serial MAC, logit streaming to softmax.
// Optional per-logit bias storage enabled by defining DENSE_OUT_LAYER_BIAS_EN.
module dense_out_layer #(
   parameter int NUM_OUT  = 5,
   parameter int IDX_W    = 3,
   parameter int NUM_IN   = 4,
   parameter int IN_IDX_W = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 feat_in,
   input  logic [IN_IDX_W-1:0]         feat_idx,
   input  logic                        feat_valid,
   input  logic                        w_we,
   input  logic [IN_IDX_W+IDX_W-1:0]   w_addr,
   input  logic [31:0]                 w_data,
   output logic [31:0]                 sf_input,
   output logic [IDX_W-1:0]            sf_input_idx,
   output logic                        start,
   input  logic                        in_ready,
   output logic                        busy,
   output logic                        frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_STREAM} state_t;

   localparam logic [IDX_W-1:0]    LAST_J = IDX_W'(NUM_OUT - 1);
   localparam logic [IN_IDX_W-1:0] LAST_I = IN_IDX_W'(NUM_IN - 1);

   state_t                state_q, state_d;
   logic [NUM_IN-1:0]     flags_q, flags_d;
   logic [IN_IDX_W-1:0]   i_q, i_d;
   logic [IDX_W-1:0]      j_q, j_d;
   logic [IDX_W-1:0]      k_q, k_d;
   logic signed [31:0]    acc_q, acc_d;
   logic                  done_q, done_d;
   logic signed [31:0]    feat_q [NUM_IN];
   logic signed [31:0]    feat_d [NUM_IN];
   logic signed [31:0]    w_q [NUM_OUT][NUM_IN];
   logic signed [31:0]    w_d [NUM_OUT][NUM_IN];
   logic signed [31:0]    logit_q [NUM_OUT];
   logic signed [31:0]    logit_d [NUM_OUT];
`ifdef DENSE_OUT_LAYER_BIAS_EN
   logic signed [31:0]    bias_q [NUM_OUT];
   logic signed [31:0]    bias_d [NUM_OUT];
`endif

   logic [IDX_W-1:0]      w_out;
   logic [IN_IDX_W-1:0]   w_in;
   logic signed [31:0]    acc_init;
   logic signed [31:0]    term;
   logic signed [31:0]    acc_next;

   assign w_out = w_addr[IN_IDX_W +: IDX_W];
   assign w_in  = w_addr[IN_IDX_W-1:0];

   always_comb begin
      state_d  = state_q;
      flags_d  = flags_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      feat_d   = feat_q;
      w_d      = w_q;
      logit_d  = logit_q;
`ifdef DENSE_OUT_LAYER_BIAS_EN
      bias_d   = bias_q;
      acc_init = bias_q[j_q];
`else
      acc_init = '0;
`endif
      // Q16.16 x Q16.16 gives Q32.32; bits [47:16] realign to Q16.16 and wrap silently
      term     = 32'((64'(feat_q[i_q]) * 64'(w_q[j_q][i_q])) >>> 16);
      acc_next = ((i_q == '0) ? acc_init : acc_q) + term;

      // The MAC reads w_q above, so a same-cycle write lands only for later products
      if (w_we) begin
         if (32'(w_out) < NUM_OUT && 32'(w_in) < NUM_IN) begin
            w_d[w_out][w_in] = w_data;
         end
`ifdef DENSE_OUT_LAYER_BIAS_EN
         else if (32'(w_out) < NUM_OUT && w_in == '1) begin
            bias_d[w_out] = w_data;
         end
`endif
      end

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (feat_valid && 32'(feat_idx) < NUM_IN) begin
               feat_d[feat_idx]  = feat_in;
               flags_d[feat_idx] = 1'b1;
               state_d           = S_LOAD;
               if (&flags_d) begin
                  state_d = S_MAC;
                  i_d     = '0;
                  j_d     = '0;
               end
            end
         end
         S_MAC: begin
            acc_d = acc_next;
            if (i_q == LAST_I) begin
               logit_d[j_q] = acc_next;
               i_d          = '0;
               if (j_q == LAST_J) begin
                  state_d = S_STREAM;
                  k_d     = '0;
               end else begin
                  j_d = j_q + IDX_W'(1);
               end
            end else begin
               i_d = i_q + IN_IDX_W'(1);
            end
         end
         S_STREAM: begin
            if (in_ready) begin
               if (k_q == LAST_J) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  flags_d = '0;
                  k_d     = '0;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         flags_q <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
      end
   end

   // Storage arrays survive reset; weights in particular must outlive an aborted frame
   always_ff @(posedge clk) begin
      feat_q  <= feat_d;
      w_q     <= w_d;
      logit_q <= logit_d;
`ifdef DENSE_OUT_LAYER_BIAS_EN
      bias_q  <= bias_d;
`endif
   end

   assign start        = (state_q == S_STREAM);
   assign sf_input     = start ? logit_q[k_q] : '0;
   assign sf_input_idx = start ? k_q : '0;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = done_q;

endmodule

// File: tb/tb_dense_out_layer.sv
// tb/tb_dense_out_layer.sv - self-checking bench for dense_out_layer with a behavioural logit model.
module tb_dense_out_layer;
   localparam int NUM_OUT  = 5;
   localparam int IDX_W    = 3;
   localparam int NUM_IN   = 4;
   localparam int IN_IDX_W = 2;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [31:0]                 feat_in;
   logic [IN_IDX_W-1:0]         feat_idx;
   logic                        feat_valid;
   logic                        w_we;
   logic [IN_IDX_W+IDX_W-1:0]   w_addr;
   logic [31:0]                 w_data;
   logic [31:0]                 sf_input;
   logic [IDX_W-1:0]            sf_input_idx;
   logic                        start;
   logic                        in_ready;
   logic                        busy;
   logic                        frame_done;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           w_m [NUM_OUT][NUM_IN];
   int           feat_m [NUM_IN];
   int           exp_logit [NUM_OUT];
   logic [31:0]  captured [NUM_OUT];
   int           exp_k = 0;
   int           xfers = 0;
   bit           chk_en = 1'b0;
   bit           done_exp = 1'b0;
   bit           done_seen = 1'b0;

   dense_out_layer #(
      .NUM_OUT(NUM_OUT), .IDX_W(IDX_W), .NUM_IN(NUM_IN), .IN_IDX_W(IN_IDX_W)
   ) dut (
      .clk(clk), .rst(rst),
      .feat_in(feat_in), .feat_idx(feat_idx), .feat_valid(feat_valid),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .sf_input(sf_input), .sf_input_idx(sf_input_idx), .start(start),
      .in_ready(in_ready), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Dot product in Q16.16 with 32-bit wrapping accumulation
   function automatic int model_logit(input int j);
      int     acc;
      longint p;
      acc = 0;
      for (int i = 0; i < NUM_IN; i++) begin
         p = longint'(feat_m[i]) * longint'(w_m[j][i]);
         acc += int'(p >>> 16);
      end
      return acc;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("frame_done", 32'(frame_done), 32'(done_exp));
         if (frame_done) done_seen = 1'b1;
         done_exp = 1'b0;
         if (start) begin
            chk("extra_start", 32'(exp_k < NUM_OUT), 32'd1);
            chk("busy_stream", 32'(busy), 32'd1);
            if (exp_k < NUM_OUT) begin
               chk("sf_input", sf_input, exp_logit[exp_k]);
               chk("sf_input_idx", 32'(sf_input_idx), exp_k);
               if (in_ready) begin
                  captured[exp_k] = sf_input;
                  if (exp_k == NUM_OUT - 1) done_exp = 1'b1;
                  exp_k++;
                  xfers++;
               end
            end
         end
      end
   end

   task automatic write_w(input int j, input int i, input logic [31:0] v);
      w_we   = 1'b1;
      w_addr = {IDX_W'(j), IN_IDX_W'(i)};
      w_data = v;
      w_m[j][i] = v;
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   task automatic feed_slot(input int i, input logic [31:0] v);
      feat_valid = 1'b1;
      feat_idx   = IN_IDX_W'(i);
      feat_in    = v;
      @(posedge clk); #1;
      feat_valid = 1'b0;
   endtask

   task automatic feed(input logic [31:0] f0, input logic [31:0] f1,
                       input logic [31:0] f2, input logic [31:0] f3);
      logic [31:0] f [NUM_IN];
      f = '{f0, f1, f2, f3};
      for (int i = 0; i < NUM_IN; i++) feat_m[i] = f[i];
      for (int j = 0; j < NUM_OUT; j++) begin
         exp_logit[j] = model_logit(j);
         captured[j]  = 32'hDEADBEEF;
      end
      exp_k = 0; xfers = 0; done_exp = 1'b0; done_seen = 1'b0; chk_en = 1'b1;
      for (int i = 0; i < NUM_IN; i++) feed_slot(i, f[i]);
   endtask

   task automatic wait_done(input bit toggle);
      for (int c = 0; c < 400 && !done_seen; c++) begin
         @(posedge clk); #1;
         if (toggle) in_ready = ~in_ready;
      end
      chk("done_timeout", 32'(done_seen), 32'd1);
      chk("xfer_count", xfers, NUM_OUT);
      chk("frame_done_pulse", 32'(frame_done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk_en   = 1'b0;
      in_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; feat_in = '0; feat_idx = '0; feat_valid = 1'b0;
      w_we = 1'b0; w_addr = '0; w_data = '0; in_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_sf_input", sf_input, 32'd0);
      chk("rst_sf_input_idx", 32'(sf_input_idx), 32'd0);
      rst = 1'b0;

      for (int j = 0; j < NUM_OUT; j++)
         for (int i = 0; i < NUM_IN; i++) write_w(j, i, 32'h00010000);

      // Slot 0 is written twice; the first value must be overwritten and not counted
      feed_slot(0, 32'h00090000);
      chk("busy_load", 32'(busy), 32'd1);
      feed(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      chk("busy_mac", 32'(busy), 32'd1);
      wait_done(1'b0);
      for (int j = 0; j < NUM_OUT; j++) chk("basic_logit", captured[j], 32'h000A0000);

      feed(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      wait_done(1'b1);
      for (int j = 0; j < NUM_OUT; j++) chk("stall_logit", captured[j], 32'h000A0000);

      feed(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      for (int c = 0; c < 200 && xfers < 2; c++) begin
         @(posedge clk); #1;
      end
      chk("reach_two_xfers", xfers, 2);
      chk_en = 1'b0; in_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_ready = 1'b1;
      chk("abort_start", 32'(start), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sf_input", sf_input, 32'd0);
      chk("abort_sf_input_idx", 32'(sf_input_idx), 32'd0);
      repeat (8) begin
         @(posedge clk); #1;
         chk("abort_no_restart", 32'(start), 32'd0);
      end
      feed(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
      wait_done(1'b0);
      for (int j = 0; j < NUM_OUT; j++) chk("post_reset_logit", captured[j], 32'h000A0000);

      for (int i = 0; i < NUM_IN; i++) write_w(2, i, 32'hFFFF0000);
      feed(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
      wait_done(1'b0);
      for (int j = 0; j < NUM_OUT; j++)
         chk("neg_weight_logit", captured[j], (j == 2) ? 32'hFFFC0000 : 32'h00040000);

      // Two wrapped terms of 0x7FFF0000*2.0 each realign to -2.0
      for (int j = 0; j < NUM_OUT; j++)
         for (int i = 0; i < NUM_IN; i++) write_w(j, i, (i < 2) ? 32'h00020000 : 32'h0);
      feed(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
      wait_done(1'b0);
      chk("wrap_logit0", captured[0], 32'hFFFC0000);
      chk("wrap_logit4", captured[4], 32'hFFFC0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
